// File: rtl/scope_trigger_capture_if.sv
// Sample-stream, trigger-control and record-read signals of the scope acquisition stage.
// The master side is the sample source and display renderer; the slave side is the capture block.
interface scope_trigger_capture_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] trig_level;
    logic              trig_slope;
    logic              arm;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              capture_done;
    logic              auto_trig;

    modport master (
        output sample_valid, sample, trig_level, trig_slope, arm, rd_addr,
        input  rd_data, busy, capture_done, auto_trig
    );

    modport slave (
        input  sample_valid, sample, trig_level, trig_slope, arm, rd_addr,
        output rd_data, busy, capture_done, auto_trig
    );
endinterface

// File: rtl/scope_trigger_capture.sv
// Pre-trigger history, level/slope trigger and post-trigger capture into a frozen record.
// Define SCOPE_AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT valid samples in WAIT_TRIG.
module scope_trigger_capture #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 640,
    parameter int ADDR_W       = 10,
    parameter int PRE_SAMPLES  = 64,
    parameter int AUTO_TIMEOUT = 4096
) (
    input logic                  clock,
    input logic                  reset_n,
    scope_trigger_capture_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_PREFILL, S_WAIT, S_POST, S_DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   PRE_X     = (ADDR_W+1)'(PRE_SAMPLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_CNT   = ADDR_W'(PRE_SAMPLES);
    localparam logic [ADDR_W-1:0] POST_LEN  = ADDR_W'(DEPTH - PRE_SAMPLES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic [ADDR_W-1:0]   trig_ptr_q, trig_ptr_d;
    logic                rd_zero_q, rd_zero_d;
    logic [DATA_W-1:0]   ram_dout_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                start_cap, accept, wr_en, real_hit, auto_hit, trig_fire;
    logic [ADDR_W-1:0]   wr_ptr_inc, cnt_inc, phys_addr;
    logic [ADDR_W:0]     trig_x, start_x, sum_x;

    assign start_cap  = bus.arm && (state_q == S_IDLE || state_q == S_DONE);
    assign accept     = bus.sample_valid &&
                        (state_q == S_PREFILL || state_q == S_WAIT || state_q == S_POST);
    assign wr_ptr_inc = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
    assign cnt_inc    = cnt_q + 1'b1;

    always_comb begin
        real_hit = 1'b0;
        if (state_q == S_WAIT && bus.sample_valid && prev_valid_q) begin
            if (bus.trig_slope)
                real_hit = (prev_q > bus.trig_level) && (bus.sample <= bus.trig_level);
            else
                real_hit = (prev_q < bus.trig_level) && (bus.sample >= bus.trig_level);
        end
    end

`ifdef SCOPE_AUTO_TRIG_EN
    localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);

    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic              auto_trig_q, auto_trig_d;

    assign auto_hit = (state_q == S_WAIT) && bus.sample_valid && !real_hit &&
                      (auto_cnt_q == AUTO_LAST);

    // Counter is only meaningful inside WAIT_TRIG, so every other state holds it at zero.
    always_comb begin
        auto_cnt_d  = '0;
        auto_trig_d = auto_trig_q;
        if (state_q == S_WAIT)
            auto_cnt_d = bus.sample_valid ? auto_cnt_q + 1'b1 : auto_cnt_q;
        if (trig_fire)
            auto_trig_d = auto_hit;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_cnt_q  <= '0;
            auto_trig_q <= 1'b0;
        end else begin
            auto_cnt_q  <= auto_cnt_d;
            auto_trig_q <= auto_trig_d;
        end
    end

    assign bus.auto_trig = auto_trig_q;
`else
    assign auto_hit      = 1'b0;
    assign bus.auto_trig = 1'b0;
`endif

    assign trig_fire = real_hit || auto_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            trig_ptr_q   <= '0;
            rd_zero_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            trig_ptr_q   <= trig_ptr_d;
            rd_zero_q    <= rd_zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE:
                if (bus.arm) state_d = (PRE_SAMPLES == 0) ? S_WAIT : S_PREFILL;
            S_PREFILL:
                if (bus.sample_valid && cnt_inc == PRE_CNT) state_d = S_WAIT;
            S_WAIT:
                if (trig_fire) state_d = (POST_LEN == '0) ? S_DONE : S_POST;
            S_POST:
                if (bus.sample_valid && cnt_inc == POST_LEN) state_d = S_DONE;
            default:
                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        trig_ptr_d   = trig_ptr_q;
        if (start_cap) begin
            wr_ptr_d     = '0;
            cnt_d        = '0;
            prev_valid_d = 1'b0;
        end else if (accept) begin
            wr_ptr_d     = wr_ptr_inc;
            prev_d       = bus.sample;
            prev_valid_d = 1'b1;
            if (state_q == S_WAIT) begin
                if (trig_fire) begin
                    trig_ptr_d = wr_ptr_q;
                    cnt_d      = '0;
                end
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_comb begin
        wr_en            = accept;
        bus.busy         = (state_q == S_PREFILL) || (state_q == S_WAIT) || (state_q == S_POST);
        bus.capture_done = (state_q == S_DONE);
        bus.rd_data      = rd_zero_q ? '0 : ram_dout_q;
    end

    // Logical index 0 is PRE_SAMPLES before the trigger; both wraps use a single DEPTH correction.
    always_comb begin
        trig_x    = {1'b0, trig_ptr_q};
        start_x   = (trig_x >= PRE_X) ? trig_x - PRE_X : trig_x + DEPTH_X - PRE_X;
        sum_x     = start_x + {1'b0, bus.rd_addr};
        phys_addr = ADDR_W'((sum_x >= DEPTH_X) ? sum_x - DEPTH_X : sum_x);
        rd_zero_d = ({1'b0, bus.rd_addr} >= DEPTH_X);
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr_q] <= bus.sample;
        ram_dout_q <= mem[phys_addr];
    end
endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture: stimulus pushes expected read data into a queue,
// a separate monitor pops and compares one cycle after each read address is presented.
module tb_scope_trigger_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   issue = 1'b0;
    bit   issue_d = 1'b0;
    int   exp_q[$];

    scope_trigger_capture_if #(.DATA_W(8), .ADDR_W(10)) bus ();

    scope_trigger_capture dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Sample value number k of each stimulus kind: rising ramp, falling ramp, constant.
    function automatic int val(input int kind, input int k);
        case (kind)
            0: return k % 256;
            1: return 255 - (k % 256);
            default: return 20;
        endcase
    endfunction

    // Trigger lands on sample 100 (rising) or 205 (falling); logical 0 is 64 samples earlier.
    function automatic int exp_rd(input int kind, input int i);
        case (kind)
            0: return (36 + i) % 256;
            1: return 255 - ((141 + i) % 256);
            default: return 20;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            issue_d = issue;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (issue_d) begin
                if (exp_q.size() == 0) begin
                    chk("rd_queue_empty", 1, 0);
                end else begin
                    chk("rd_data", int'(bus.rd_data), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic capture(input int kind, input bit gaps, input int arm_at,
                           input int abort_at, input int budget);
        int k = 0;
        int cyc = 0;
        @(negedge clk);
        bus.arm = 1'b1;
        bus.sample_valid = 1'b0;
        @(negedge clk);
        bus.arm = 1'b0;
        while (!bus.capture_done && cyc < budget) begin
            bus.arm = 1'b0;
            bus.sample_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
            if (bus.sample_valid) begin
                bus.sample = 8'(val(kind, k));
                if (k == arm_at) bus.arm = 1'b1;
                if (k == abort_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("abort_busy", int'(bus.busy), 0);
                    chk("abort_done", int'(bus.capture_done), 0);
                    @(negedge clk);
                    bus.sample_valid = 1'b0;
                    rst_n = 1'b1;
                    return;
                end
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        bus.arm = 1'b0;
    endtask

    task automatic readback(input int kind, input int exp_auto);
        chk("done", int'(bus.capture_done), 1);
        chk("busy_done", int'(bus.busy), 0);
        chk("auto_trig", int'(bus.auto_trig), exp_auto);
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            bus.rd_addr = 10'(i);
            issue = 1'b1;
            exp_q.push_back(exp_rd(kind, i));
        end
        @(negedge clk);
        bus.rd_addr = 10'd700;
        exp_q.push_back(0);
        @(negedge clk);
        bus.rd_addr = 10'd64;
        exp_q.push_back(exp_rd(kind, 64));
        @(negedge clk);
        issue = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rd_drained", exp_q.size(), 0);
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample = '0;
        bus.trig_level = 8'd100;
        bus.trig_slope = 1'b0;
        bus.arm = 1'b0;
        bus.rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.capture_done), 0);
        chk("reset_auto", int'(bus.auto_trig), 0);
        chk("reset_rd_data", int'(bus.rd_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("capture rising level=100");
        capture(0, 1'b0, -1, -1, 3000);
        readback(0, 0);

        $display("capture falling level=50");
        bus.trig_level = 8'd50;
        bus.trig_slope = 1'b1;
        capture(1, 1'b0, -1, -1, 3000);
        readback(1, 0);

        $display("capture rising with valid gaps");
        bus.trig_level = 8'd100;
        bus.trig_slope = 1'b0;
        capture(0, 1'b1, -1, -1, 4000);
        readback(0, 0);

        $display("capture rising with arm during WAIT_TRIG");
        capture(0, 1'b0, 80, -1, 3000);
        readback(0, 0);

        $display("capture aborted by reset in POST, then fresh capture");
        capture(0, 1'b0, -1, 300, 3000);
        chk("after_abort_busy", int'(bus.busy), 0);
        capture(0, 1'b0, -1, -1, 3000);
        readback(0, 0);

        $display("capture constant 20 below level 100");
        capture(2, 1'b0, -1, -1, 10000);
`ifdef SCOPE_AUTO_TRIG_EN
        readback(2, 1);
`else
        chk("const_busy", int'(bus.busy), 1);
        chk("const_done", int'(bus.capture_done), 0);
        chk("const_auto", int'(bus.auto_trig), 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("capture rising after constant run");
        capture(0, 1'b0, -1, -1, 3000);
        readback(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scope_trigger_capture.md
Name: scope_trigger_capture

Overview:
- Acquisition stage directly upstream of the VGA scope display in FPGA_MiniProject.
- Accepts a stream of ADC samples and arms on request.
- Keeps a circular pre-trigger history, detects a level/slope trigger, and captures a fixed-length post-trigger record into on-chip RAM.
- Freezes the record and presents it to the display renderer through a random-access read port, indexed by screen column.

Parameters:
- DATA_W, 8, sample width in bits.
- DEPTH, 640, record length in samples (one per VGA column).
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= DEPTH.
- PRE_SAMPLES, 64, samples kept before the trigger point; 0 <= PRE_SAMPLES < DEPTH.
- AUTO_TIMEOUT, 4096, valid samples waited before a forced trigger (used only with AUTO_TRIG_EN).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  sample qualifier; one sample per high cycle.
- sample  in  DATA_W  unsigned ADC sample.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- trig_slope  in  1  0 = rising edge, 1 = falling edge.
- arm  in  1  single-cycle request to start a capture.
- rd_addr  in  ADDR_W  logical read index 0..DEPTH-1; 0 is the oldest sample.
- rd_data  out  DATA_W  registered read data.
- busy  out  1  high in PREFILL, WAIT_TRIG and POST.
- capture_done  out  1  high in DONE; record is stable.
- auto_trig  out  1  last trigger was forced (0 when macro absent).

Behaviour:
- Reset: state IDLE; all outputs 0; wr_ptr, counters and prev_valid cleared. RAM contents are not cleared. Asserting reset_n low mid-capture aborts to IDLE immediately.
- Writes: each write stores sample at wr_ptr, then wr_ptr increments, wrapping DEPTH-1 -> 0. Writes happen only when sample_valid=1 in PREFILL, WAIT_TRIG or POST.
- prev register: loaded on every accepted sample; prev_valid is set on the first accepted sample after arm.
- IDLE: arm=1 -> PREFILL. wr_ptr=0, cnt=0, prev_valid=0. If PRE_SAMPLES=0, go directly to WAIT_TRIG.
- PREFILL: write samples. When cnt reaches PRE_SAMPLES -> WAIT_TRIG. No trigger evaluation in this state.
- WAIT_TRIG trigger condition, evaluated on each valid sample:
  - rising: prev_valid && prev < trig_level && sample >= trig_level.
  - falling: prev_valid && prev > trig_level && sample <= trig_level.
- On trigger: the triggering sample is written, trig_ptr is set to its address, state -> POST, post_cnt=0. The first valid sample after arm can never trigger.
- POST: write DEPTH-PRE_SAMPLES-1 further samples, then -> DONE. Total record = DEPTH samples.
- DONE: no writes. capture_done=1. arm=1 -> PREFILL (re-arm, same initialisation as from IDLE).
- arm in PREFILL, WAIT_TRIG or POST is ignored.
- Read mapping: start = (trig_ptr - PRE_SAMPLES) mod DEPTH; physical address = (start + rd_addr) mod DEPTH.
  - Modular arithmetic is done in ADDR_W+1 bits with a conditional DEPTH subtract/add; no power-of-two assumption.
- Read port: rd_data valid one cycle after rd_addr, in all states.
  - rd_addr >= DEPTH -> rd_data = 0.
  - Reads outside DONE return the live, unstable contents.
- sample_valid gaps: state and counters hold; trigger comparison uses the last accepted sample as prev.
- RAM: inferred single write port, single registered read port. Read and write to the same address in one cycle returns the old data.

Optional Feature:
- Macro: SCOPE_AUTO_TRIG_EN.
- Defined: in WAIT_TRIG, a counter increments on each valid sample without a trigger. When it reaches AUTO_TIMEOUT, that sample is treated as the trigger and auto_trig=1. A real trigger clears auto_trig. The counter resets on entry to WAIT_TRIG.
- Undefined: no counter logic; auto_trig tied 0. WAIT_TRIG waits indefinitely.

Test Plan:
- Rising trigger: defaults, ramp 0,1,..,255 repeating, valid every cycle, trig_level=100, trig_slope=0, arm at sample 0 -> triggers on value 100. After capture_done: rd_addr 0 -> 36, 64 -> 100, 639 -> 163.
- Falling trigger: ramp 255 down to 0, trig_level=50, trig_slope=1 -> trigger on value 50. rd_addr 64 -> 50, rd_addr 0 -> 114.
- Valid gaps: same ramp as the rising test, sample_valid toggling 1/0 -> identical readback to the rising test; capture_done asserts about 2x later.
- Ignored arm and reset abort: arm pulsed during WAIT_TRIG -> no restart, same result as the rising test. reset_n pulsed low during POST -> busy=0, capture_done=0 immediately, state IDLE; a fresh arm then captures correctly.
- Constant input with SCOPE_AUTO_TRIG_EN: sample held at 20, level 100 -> with macro, forced trigger after 4096 samples, auto_trig=1, all reads 20. Without macro, busy stays 1 and capture_done stays 0 for 10000 cycles.
- Read latency: after capture_done, rd_addr=700 -> rd_data=0 one cycle later; consecutive rd_addr 0,1,2 -> data appears one cycle delayed.
